// File: rtl/dir_to_xy_if.sv
// Button/cursor bundle for dir_to_xy: five raw buttons in, x/y position and
// change strobe out.
interface dir_to_xy_if;
  logic [4:0]  buttons;
  logic [10:0] x;
  logic [10:0] y;
  logic        valid;

  modport master (output buttons, input x, y, valid);
  modport slave  (input buttons, output x, y, valid);
endinterface

// File: rtl/dir_to_xy.sv
// Direction buttons to x/y cursor: synchronise, debounce, step on press and
// auto-repeat while held. Optional step acceleration under DIR_TO_XY_ACCEL_EN.
module dir_to_xy #(
  parameter int MID_X      = 500,
  parameter int MID_Y      = 500,
  parameter int X_MAX      = 1023,
  parameter int Y_MAX      = 1023,
  parameter int STEP       = 4,
  parameter int DEBOUNCE   = 16,
  parameter int REPEAT_DIV = 120000
) (
  input  logic       clk,
  input  logic       reset_n,
  dir_to_xy_if.slave bus
);

  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int RP_W = (REPEAT_DIV > 1) ? $clog2(REPEAT_DIV) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  logic [4:0]      sync1, sync2, deb;
  logic [DB_W-1:0] db_cnt [5];
  logic [3:0]      dir, dir_prev, rise;
  logic            centre, press, held, rpt_done;
  state_t          state, state_nx;
  logic [RP_W-1:0] rpt_cnt;
  logic            step_req, auto_rep, do_step;
  logic [11:0]     step_use;
  logic [10:0]     x_q, y_q, x_nx, y_nx;
  logic            valid_q;
  logic            mv_up, mv_right, mv_down, mv_left;

  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // blocking assignments here would turn the two-flop chain into a wire.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.buttons;
      sync2 <= sync1;
    end
  end

  // NOTE: db_cnt is a small array of flops, not a RAM, so it can and must be
  // reset like any other register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign centre   = deb[0];
  assign dir      = deb[4:1];
  assign rise     = dir & ~dir_prev;
  assign press    = |rise;
  assign held     = |dir;
  assign rpt_done = (rpt_cnt == RP_W'(REPEAT_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      dir_prev <= '0;
      rpt_cnt  <= '0;
    end else begin
      state    <= state_nx;
      dir_prev <= dir;
      if (step_req || state != HOLD || !held) rpt_cnt <= '0;
      else                                    rpt_cnt <= rpt_cnt + 1'b1;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (press) state_nx = HOLD;
      HOLD:    if (!held) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    step_req = 1'b0;
    auto_rep = 1'b0;
    case (state)
      IDLE: step_req = press;
      HOLD: begin
        if (held) begin
          if (press) begin
            step_req = 1'b1;
          end else if (rpt_done) begin
            step_req = 1'b1;
            auto_rep = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Centre owns the position while held; the repeat timer keeps running.
  assign do_step = step_req & ~centre;

`ifdef DIR_TO_XY_ACCEL_EN
  logic [11:0] step_amt;
  logic [2:0]  acc_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_amt <= 12'(STEP);
      acc_cnt  <= '0;
    end else if (centre || press || state == IDLE) begin
      step_amt <= 12'(STEP);
      acc_cnt  <= '0;
    end else if (do_step && auto_rep) begin
      acc_cnt <= acc_cnt + 1'b1;
      if (acc_cnt == 3'd7 && step_amt < 12'(4 * STEP)) step_amt <= step_amt << 1;
    end
  end

  // A press edge always moves by the base step, even mid-hold.
  assign step_use = press ? 12'(STEP) : step_amt;
`else
  assign step_use = 12'(STEP);
`endif

  function automatic logic [10:0] sat_add(logic [10:0] v, logic [11:0] d, int hi);
    logic [11:0] s;
    s = {1'b0, v} + d;
    return (s > 12'(hi)) ? 11'(hi) : s[10:0];
  endfunction

  // Underflow shows up as bit 11 set in the 12-bit difference.
  function automatic logic [10:0] sat_sub(logic [10:0] v, logic [11:0] d);
    logic [11:0] s;
    s = {1'b0, v} - d;
    return s[11] ? 11'd0 : s[10:0];
  endfunction

  assign mv_up    = dir[0] & ~dir[2];
  assign mv_right = dir[1] & ~dir[3];
  assign mv_down  = dir[2] & ~dir[0];
  assign mv_left  = dir[3] & ~dir[1];

  always_comb begin
    x_nx = x_q;
    y_nx = y_q;
    if (centre) begin
      x_nx = 11'(MID_X);
      y_nx = 11'(MID_Y);
    end else if (do_step) begin
      if (mv_right) x_nx = sat_add(x_q, step_use, X_MAX);
      if (mv_left)  x_nx = sat_sub(x_q, step_use);
      if (mv_up)    y_nx = sat_add(y_q, step_use, Y_MAX);
      if (mv_down)  y_nx = sat_sub(y_q, step_use);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q     <= 11'(MID_X);
      y_q     <= 11'(MID_Y);
      valid_q <= 1'b0;
    end else begin
      x_q     <= x_nx;
      y_q     <= y_nx;
      valid_q <= (x_nx != x_q) || (y_nx != y_q);
    end
  end

  assign bus.x     = x_q;
  assign bus.y     = y_q;
  assign bus.valid = valid_q;

endmodule
